// File: rtl/target_sequencer_if.sv
// target_sequencer_if
//
// Groups the game-side signals of target_sequencer into one bundle.
//   start      : level request to begin a game (driven by the player/controller side)
//   sw[15:0]   : player switches, already synchronous to clk
//   rnd[3:0]   : current target index for the LED select stage
//   off        : 1 blanks every LED
//   score[7:0] : hits in the current game, saturating at 255
//   lives[2:0] : remaining lives
//   hit, miss  : one-cycle event pulses
//   game_over  : high while the game is over
//
// Modports:
//   master : the controller/player side (drives start and sw)
//   slave  : the sequencer itself (drives the game outputs)

interface target_sequencer_if;
    logic        start;
    logic [15:0] sw;
    logic [3:0]  rnd;
    logic        off;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic        hit;
    logic        miss;
    logic        game_over;

    modport master (
        output start, sw,
        input  rnd, off, score, lives, hit, miss, game_over
    );

    modport slave (
        input  start, sw,
        output rnd, off, score, lives, hit, miss, game_over
    );
endinterface

// File: rtl/target_sequencer.sv
// target_sequencer
//
// Whack-a-mole style game sequencer feeding the LED one-hot select stage.
// It chooses which of the 16 LEDs is the current target (rnd), blanks the
// display between targets (off), watches the player's switches for rising
// edges, and keeps the score and the remaining lives. All pacing comes from
// an internal tick divider so the LED stage needs no timing of its own.
//
// Ports:
//   clk   : system clock, everything on the rising edge
//   reset : asynchronous, active-high; returns to IDLE with the LFSR at SEED
//   bus   : target_sequencer_if.slave (start, sw in; rnd, off, score, lives,
//           hit, miss, game_over out; all outputs registered)
//
// Parameters:
//   TICK_DIV  : clk cycles per game tick (>= 2)
//   ON_TICKS  : ticks a target stays lit (>= 1)
//   GAP_TICKS : blank ticks between targets (>= 1)
//   LIVES     : lives at game start (1..7)
//   SEED      : LFSR reset value (nonzero)
//
// Optional feature, macro TARGET_SPEEDUP_EN:
//   When defined, the lit time shrinks by one tick after every 8th hit, down
//   to a floor of one tick, and is restored to ON_TICKS on every start.
//   When undefined, the lit time is always ON_TICKS and no extra register
//   exists.

module target_sequencer #(
    parameter int          TICK_DIV  = 25_000_000,
    parameter int          ON_TICKS  = 4,
    parameter int          GAP_TICKS = 1,
    parameter int          LIVES     = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    target_sequencer_if.slave bus
);

    localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(MAXT + 1);

    localparam logic [CW-1:0] CYC_LAST  = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [15:0]   lfsr, lfsr_n;
    logic [15:0]   sw_q;
    logic [15:0]   rise;
    logic [15:0]   target_mask;
    logic [CW-1:0] cyc, cyc_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          tick;
    logic          enter;
    logic          miss_ev;

    logic [3:0]    rnd_r, rnd_n;
    logic          off_r, off_n;
    logic [7:0]    score_r, score_n;
    logic [2:0]    lives_r, lives_n;
    logic          hit_r, hit_n;
    logic          miss_r, miss_n;
    logic          over_r, over_n;

    // Last tick index of a SHOW phase; shrinks with score when speedup is built
    logic [TW-1:0] show_last;

`ifdef TARGET_SPEEDUP_EN
    logic [TW-1:0] lit, lit_n;
    assign show_last = lit - TW'(1);
`else
    assign show_last = TW'(ON_TICKS - 1);
`endif

    // A switch counts only on its 0->1 transition, so a held switch never
    // re-triggers after a state change.
    assign rise        = bus.sw & ~sw_q;
    assign target_mask = 16'd1 << rnd_r;
    assign tick        = (cyc == CYC_LAST);

    assign bus.rnd       = rnd_r;
    assign bus.off       = off_r;
    assign bus.score     = score_r;
    assign bus.lives     = lives_r;
    assign bus.hit       = hit_r;
    assign bus.miss      = miss_r;
    assign bus.game_over = over_r;

    // Next-state and next-output logic. "enter" marks any state entry so the
    // cycle and tick counters restart and every phase has an exact length.
    always_comb begin
        state_n = state;
        rnd_n   = rnd_r;
        score_n = score_r;
        lives_n = lives_r;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        enter   = 1'b0;
        miss_ev = 1'b0;
`ifdef TARGET_SPEEDUP_EN
        lit_n   = lit;
`endif

        case (state)
            IDLE, OVER: begin
                if (bus.start) begin
                    score_n = 8'd0;
                    lives_n = 3'(LIVES);
                    state_n = GAP;
                    enter   = 1'b1;
`ifdef TARGET_SPEEDUP_EN
                    lit_n   = TW'(ON_TICKS);
`endif
                end
            end

            GAP: begin
                if (tick && (tcnt == GAP_LAST)) begin
                    state_n = SHOW;
                    enter   = 1'b1;
                    // Never repeat the previous target back to back
                    if (lfsr[3:0] == rnd_r) begin
                        rnd_n = lfsr[3:0] + 4'd1;
                    end else begin
                        rnd_n = lfsr[3:0];
                    end
                end
            end

            SHOW: begin
                // Any wrong switch wins over a correct one so mashing never scores
                if (|(rise & ~target_mask)) begin
                    miss_ev = 1'b1;
                end else if (|(rise & target_mask)) begin
                    hit_n   = 1'b1;
                    score_n = (score_r == 8'hFF) ? score_r : score_r + 8'd1;
                    state_n = GAP;
                    enter   = 1'b1;
`ifdef TARGET_SPEEDUP_EN
                    if ((score_r != 8'hFF) && (score_n[2:0] == 3'd0) && (lit > TW'(1))) begin
                        lit_n = lit - TW'(1);
                    end
`endif
                end else if (tick && (tcnt == show_last)) begin
                    miss_ev = 1'b1;
                end

                if (miss_ev) begin
                    miss_n  = 1'b1;
                    lives_n = lives_r - 3'd1;
                    state_n = (lives_n == 3'd0) ? OVER : GAP;
                    enter   = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        if (enter) begin
            cyc_n  = '0;
            tcnt_n = '0;
        end else if (tick) begin
            cyc_n  = '0;
            tcnt_n = tcnt + TW'(1);
        end else begin
            cyc_n  = cyc + CW'(1);
            tcnt_n = tcnt;
        end

        off_n  = (state_n != SHOW);
        over_n = (state_n == OVER);

        lfsr_n = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ LFSR_TAPS) : {1'b0, lfsr[15:1]};
    end

    // State register plus every registered output; the LFSR free-runs in all
    // states so the target sequence depends on player reaction time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lfsr    <= SEED;
            sw_q    <= 16'd0;
            cyc     <= '0;
            tcnt    <= '0;
            rnd_r   <= 4'd0;
            off_r   <= 1'b1;
            score_r <= 8'd0;
            lives_r <= 3'd0;
            hit_r   <= 1'b0;
            miss_r  <= 1'b0;
            over_r  <= 1'b0;
`ifdef TARGET_SPEEDUP_EN
            lit     <= TW'(ON_TICKS);
`endif
        end else begin
            state   <= state_n;
            lfsr    <= lfsr_n;
            sw_q    <= bus.sw;
            cyc     <= cyc_n;
            tcnt    <= tcnt_n;
            rnd_r   <= rnd_n;
            off_r   <= off_n;
            score_r <= score_n;
            lives_r <= lives_n;
            hit_r   <= hit_n;
            miss_r  <= miss_n;
            over_r  <= over_n;
`ifdef TARGET_SPEEDUP_EN
            lit     <= lit_n;
`endif
        end
    end

endmodule

// File: tb/tb_target_sequencer.sv
// tb_target_sequencer
//
// Directed bench for target_sequencer with TICK_DIV=4, ON_TICKS=3,
// GAP_TICKS=1, LIVES=3 (speedup macro undefined). Inputs are driven and
// outputs sampled on the falling clock edge. A reference Galois LFSR runs
// alongside the design so every new target index can be predicted.

module tb_target_sequencer;

    localparam int          TICK_DIV  = 4;
    localparam int          ON_TICKS  = 3;
    localparam int          GAP_TICKS = 1;
    localparam int          LIVES     = 3;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;
    logic [3:0]  last_rnd;

    always #5 clk = ~clk;

    target_sequencer_if bus ();

    target_sequencer #(
        .TICK_DIV (TICK_DIV),
        .ON_TICKS (ON_TICKS),
        .GAP_TICKS(GAP_TICKS),
        .LIVES    (LIVES),
        .SEED     (SEED)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // lfsr_prev holds the value the design saw on the most recent edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_m    <= SEED;
            lfsr_prev <= SEED;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= lfsr_step(lfsr_m);
        end
    end

    // Waits (bounded) for the display to light; returns the falling-edge
    // count (or -1) and the predicted target, and records it as last_rnd.
    task automatic await_show(output int n, output logic [3:0] exp_rnd);
        n       = -1;
        exp_rnd = 4'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.off === 1'b0) begin
                n = k;
                break;
            end
        end
        if (n > 0) begin
            exp_rnd  = (lfsr_prev[3:0] == last_rnd) ? lfsr_prev[3:0] + 4'd1 : lfsr_prev[3:0];
            last_rnd = exp_rnd;
        end
    endtask

    task automatic applyStimulus_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sw    = 16'd0;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        last_rnd = 4'd0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.off !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_off: got %0b expected 1", bus.off);
        end
        checks++;
        if (bus.lives !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_lives: got %0d expected 0", bus.lives);
        end
        checks++;
        if (bus.score !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_score: got %0d expected 0", bus.score);
        end
        checks++;
        if (bus.game_over !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_game_over: got %0b expected 0", bus.game_over);
        end
        checks++;
        if ({bus.hit, bus.miss, bus.rnd} !== 6'd0) begin
            failures++;
            $display("[TB] FAIL reset_pulses_rnd: got hit=%0b miss=%0b rnd=%0d expected all 0",
                     bus.hit, bus.miss, bus.rnd);
        end
    endtask

    task automatic test_start();
        int n;
        logic [3:0] exp_rnd;
        applyStimulus_start();
        checks++;
        if (bus.lives !== 3'd3 || bus.game_over !== 1'b0 || bus.off !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_entry: got lives=%0d over=%0b off=%0b expected 3 0 1",
                     bus.lives, bus.game_over, bus.off);
        end
        await_show(n, exp_rnd);
        checks++;
        if (n != 4) begin
            failures++;
            $display("[TB] FAIL gap_length: got %0d cycles expected 4", n);
        end
        checks++;
        if (bus.rnd !== exp_rnd) begin
            failures++;
            $display("[TB] FAIL first_target: got %0d expected %0d", bus.rnd, exp_rnd);
        end
    endtask

    task automatic test_hit();
        int n;
        logic [3:0] exp_rnd;
        logic [3:0] prev;
        prev   = last_rnd;
        bus.sw = 16'd1 << bus.rnd;
        @(negedge clk);
        checks++;
        if (bus.hit !== 1'b1 || bus.miss !== 1'b0 || bus.score !== 8'd1 || bus.off !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hit_event: got hit=%0b miss=%0b score=%0d off=%0b expected 1 0 1 1",
                     bus.hit, bus.miss, bus.score, bus.off);
        end
        bus.sw = 16'd0;
        @(negedge clk);
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hit_one_cycle: got %0b expected 0", bus.hit);
        end
        await_show(n, exp_rnd);
        checks++;
        if (n != 3) begin
            failures++;
            $display("[TB] FAIL gap_after_hit: got %0d cycles expected 3", n);
        end
        checks++;
        if (bus.rnd !== exp_rnd || bus.rnd === prev) begin
            failures++;
            $display("[TB] FAIL next_target: got %0d expected %0d (previous %0d)", bus.rnd, exp_rnd, prev);
        end
    endtask

    task automatic test_timeout();
        int n;
        int k;
        logic [3:0] exp_rnd;
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.miss === 1'b1) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k != 12) begin
            failures++;
            $display("[TB] FAIL timeout_cycles: got %0d expected 12", k);
        end
        checks++;
        if (bus.lives !== 3'd2 || bus.off !== 1'b1 || bus.hit !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_lives: got lives=%0d off=%0b hit=%0b expected 2 1 0",
                     bus.lives, bus.off, bus.hit);
        end
        // start during GAP must be ignored
        applyStimulus_start();
        @(negedge clk);
        checks++;
        if (bus.lives !== 3'd2 || bus.score !== 8'd1) begin
            failures++;
            $display("[TB] FAIL start_in_gap: got lives=%0d score=%0d expected 2 1", bus.lives, bus.score);
        end
        await_show(n, exp_rnd);
        // start during SHOW must be ignored too
        applyStimulus_start();
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.miss === 1'b1) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k < 0 || bus.lives !== 3'd1) begin
            failures++;
            $display("[TB] FAIL second_timeout: got lives=%0d wait=%0d expected lives 1", bus.lives, k);
        end
        await_show(n, exp_rnd);
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.miss === 1'b1) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k != 12 || bus.lives !== 3'd0 || bus.game_over !== 1'b1 || bus.off !== 1'b1) begin
            failures++;
            $display("[TB] FAIL game_over: got wait=%0d lives=%0d over=%0b off=%0b expected 12 0 1 1",
                     k, bus.lives, bus.game_over, bus.off);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (bus.score !== 8'd1 || bus.game_over !== 1'b1 || bus.off !== 1'b1) begin
            failures++;
            $display("[TB] FAIL over_hold: got score=%0d over=%0b off=%0b expected 1 1 1",
                     bus.score, bus.game_over, bus.off);
        end
        applyStimulus_start();
        checks++;
        if (bus.score !== 8'd0 || bus.lives !== 3'd3 || bus.game_over !== 1'b0) begin
            failures++;
            $display("[TB] FAIL restart: got score=%0d lives=%0d over=%0b expected 0 3 0",
                     bus.score, bus.lives, bus.game_over);
        end
        await_show(n, exp_rnd);
        checks++;
        if (n != 4 || bus.rnd !== exp_rnd) begin
            failures++;
            $display("[TB] FAIL restart_target: got wait=%0d rnd=%0d expected 4 %0d", n, bus.rnd, exp_rnd);
        end
    endtask

    task automatic test_mash();
        bus.sw = (16'd1 << bus.rnd) | (16'd1 << (bus.rnd ^ 4'd1));
        @(negedge clk);
        checks++;
        if (bus.miss !== 1'b1 || bus.hit !== 1'b0 || bus.score !== 8'd0 || bus.lives !== 3'd2 ||
            bus.off !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mash: got miss=%0b hit=%0b score=%0d lives=%0d off=%0b expected 1 0 0 2 1",
                     bus.miss, bus.hit, bus.score, bus.lives, bus.off);
        end
        bus.sw = 16'd0;
    endtask

    task automatic test_saturation();
        int n;
        int bad_rnd;
        int bad_hit;
        logic [3:0] exp_rnd;
        bad_rnd = 0;
        bad_hit = 0;
        for (int i = 0; i < 255; i++) begin
            await_show(n, exp_rnd);
            if (n < 0 || bus.rnd !== exp_rnd) bad_rnd++;
            bus.sw = 16'd1 << bus.rnd;
            @(negedge clk);
            if (bus.hit !== 1'b1) bad_hit++;
            bus.sw = 16'd0;
        end
        checks++;
        if (bad_rnd != 0) begin
            failures++;
            $display("[TB] FAIL target_sequence: got %0d wrong targets expected 0", bad_rnd);
        end
        checks++;
        if (bad_hit != 0 || bus.score !== 8'd255) begin
            failures++;
            $display("[TB] FAIL score_255: got score=%0d missing_hits=%0d expected 255 0", bus.score, bad_hit);
        end
        await_show(n, exp_rnd);
        bus.sw = 16'd1 << bus.rnd;
        @(negedge clk);
        checks++;
        if (bus.hit !== 1'b1 || bus.score !== 8'd255 || bus.lives !== 3'd2) begin
            failures++;
            $display("[TB] FAIL score_saturate: got hit=%0b score=%0d lives=%0d expected 1 255 2",
                     bus.hit, bus.score, bus.lives);
        end
        bus.sw = 16'd0;
    endtask

    task automatic test_reset_mid_game();
        int n;
        logic [3:0] exp_rnd;
        await_show(n, exp_rnd);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.off !== 1'b1 || bus.score !== 8'd0 || bus.lives !== 3'd0 || bus.rnd !== 4'd0 ||
            bus.hit !== 1'b0 || bus.miss !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_game: got off=%0b score=%0d lives=%0d rnd=%0d hit=%0b miss=%0b",
                     bus.off, bus.score, bus.lives, bus.rnd, bus.hit, bus.miss);
        end
        @(negedge clk);
        reset    = 1'b0;
        last_rnd = 4'd0;
        repeat (2) @(negedge clk);
        applyStimulus_start();
        await_show(n, exp_rnd);
        checks++;
        if (n != 4 || bus.rnd !== exp_rnd) begin
            failures++;
            $display("[TB] FAIL reseed_target: got wait=%0d rnd=%0d expected 4 %0d", n, bus.rnd, exp_rnd);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_timeout();
        test_mash();
        test_saturation();
        test_reset_mid_game();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
